// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding and stall sequencing for the 5-stage pipeline
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i, opcode_i,
//   rs1_i, rs2_i, rd_i      decoded fields of the ID-stage instruction
//   branch_taken_i          EX resolved a taken redirect
//   mem_busy_i              data memory not ready; freeze the pipeline
//   stall_if_o, stall_id_o  hold PC / IF-ID register
//   bubble_ex_o             load a NOP into ID/EX
//   flush_if_id_o           invalidate IF/ID
//   freeze_o                hold every pipeline register
//   fwd_a_sel_o/fwd_b_sel_o EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   id_bypass_a_o/_b_o      ID regfile read takes WB write data
//   stall_cnt_o             saturating stall-cycle counter
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             bubble_ex_o,
    output logic             flush_if_id_o,
    output logic             freeze_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             id_bypass_a_o,
    output logic             id_bypass_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic state;

    // ID-stage decode
    logic id_wr, id_load, id_use1, id_use2;

    // Shadow pipeline
    logic       ex_valid, ex_wr, ex_load, ex_use1, ex_use2;
    logic [4:0] ex_rd, ex_rs1, ex_rs2;
    logic       mem_wr, wb_wr;
    logic [4:0] mem_rd, wb_rd;

    logic load_use, frozen, stall_event;

    always_comb begin
        id_wr   = 1'b0;
        id_load = 1'b0;
        id_use1 = 1'b0;
        id_use2 = 1'b0;
        if (valid_i) begin
            // rd=x0 never counts as a write, which also keeps x0 out of load-use
            id_wr   = (opcode_i inside {OP_LOAD, OP_IMM, OP_AUIPC, OP_REG,
                                        OP_LUI, OP_JALR, OP_JAL}) && (rd_i != 5'd0);
            id_load = (opcode_i == OP_LOAD) && (rd_i != 5'd0);
            id_use1 = !(opcode_i inside {OP_LUI, OP_AUIPC, OP_JAL});
            id_use2 = opcode_i inside {OP_REG, OP_STORE, OP_BRANCH};
        end
    end

    assign load_use = ex_valid && ex_load &&
                      ((id_use1 && (ex_rd == rs1_i)) || (id_use2 && (ex_rd == rs2_i)));

    // The shadow also holds in the HOLD cycle where busy has just dropped
    assign frozen      = mem_busy_i || (state == ST_HOLD);
    assign stall_event = mem_busy_i || (!branch_taken_i && load_use);

    always_comb begin
        stall_if_o    = 1'b0;
        stall_id_o    = 1'b0;
        bubble_ex_o   = 1'b0;
        flush_if_id_o = 1'b0;
        freeze_o      = 1'b0;
        fwd_a_sel_o   = 2'b00;
        fwd_b_sel_o   = 2'b00;
        id_bypass_a_o = 1'b0;
        id_bypass_b_o = 1'b0;
        if (!rst_i) begin
            if (mem_busy_i) begin
                // A pending redirect stays in EX and is acted on once busy drops
                freeze_o   = 1'b1;
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end else if (branch_taken_i) begin
                flush_if_id_o = 1'b1;
                bubble_ex_o   = 1'b1;
            end else if (load_use) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end

            if (ex_use1 && mem_wr && (mem_rd == ex_rs1))
                fwd_a_sel_o = 2'b01;
            else if (ex_use1 && wb_wr && (wb_rd == ex_rs1))
                fwd_a_sel_o = 2'b10;

            if (ex_use2 && mem_wr && (mem_rd == ex_rs2))
                fwd_b_sel_o = 2'b01;
            else if (ex_use2 && wb_wr && (wb_rd == ex_rs2))
                fwd_b_sel_o = 2'b10;

            id_bypass_a_o = id_use1 && wb_wr && (wb_rd == rs1_i);
            id_bypass_b_o = id_use2 && wb_wr && (wb_rd == rs2_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (mem_busy_i)  state <= ST_HOLD;
                ST_HOLD: if (!mem_busy_i) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_load  <= 1'b0;
            ex_use1  <= 1'b0;
            ex_use2  <= 1'b0;
            ex_rd    <= 5'd0;
            ex_rs1   <= 5'd0;
            ex_rs2   <= 5'd0;
            mem_wr   <= 1'b0;
            mem_rd   <= 5'd0;
            wb_wr    <= 1'b0;
            wb_rd    <= 5'd0;
        end else if (!frozen) begin
            if (bubble_ex_o) begin
                ex_valid <= 1'b0;
                ex_wr    <= 1'b0;
                ex_load  <= 1'b0;
                ex_use1  <= 1'b0;
                ex_use2  <= 1'b0;
                ex_rd    <= 5'd0;
                ex_rs1   <= 5'd0;
                ex_rs2   <= 5'd0;
            end else begin
                ex_valid <= valid_i;
                ex_wr    <= id_wr;
                ex_load  <= id_load;
                ex_use1  <= id_use1;
                ex_use2  <= id_use2;
                ex_rd    <= rd_i;
                ex_rs1   <= rs1_i;
                ex_rs2   <= rs2_i;
            end
            mem_wr <= ex_wr;
            mem_rd <= ex_rd;
            wb_wr  <= mem_wr;
            wb_rd  <= mem_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if (stall_event && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] ALU  = 7'b0110011;
    localparam logic [6:0] BEQ  = 7'b1100011;

    // ctl bit order: stall_if, stall_id, bubble, flush, freeze, fwd_a[1:0], fwd_b[1:0], byp_a, byp_b
    localparam logic [10:0] C_NONE  = 11'b000_00_00_00_00;
    localparam logic [10:0] C_LDUSE = 11'b111_00_00_00_00;
    localparam logic [10:0] C_BRANCH = 11'b001_10_00_00_00;
    localparam logic [10:0] C_BUSY  = 11'b110_01_00_00_00;
    localparam logic [10:0] C_FA10  = 11'b000_00_10_00_00;
    localparam logic [10:0] C_FA01  = 11'b000_00_01_00_00;
    localparam logic [10:0] C_FAB01 = 11'b000_00_01_01_00;
    localparam logic [10:0] C_BYPA  = 11'b000_00_00_00_10;

    typedef struct packed {
        logic             v;
        logic [6:0]       op;
        logic [4:0]       r1;
        logic [4:0]       r2;
        logic [4:0]       rd;
        logic             br;
        logic             busy;
        logic             rst;
        logic [10:0]      ctl;
        logic [CNT_W-1:0] cnt;
    } row_t;

    logic             clk_i = 1'b0;
    logic             rst_i, valid_i, branch_taken_i, mem_busy_i;
    logic [6:0]       opcode_i;
    logic [4:0]       rs1_i, rs2_i, rd_i;
    logic             stall_if_o, stall_id_o, bubble_ex_o, flush_if_id_o, freeze_o;
    logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
    logic             id_bypass_a_o, id_bypass_b_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [10:0]      ctl_obs;

    int pass_cnt = 0;
    int total    = 0;
    row_t exp_q[$];

    always #5 clk_i = ~clk_i;

    assign ctl_obs = {stall_if_o, stall_id_o, bubble_ex_o, flush_if_id_o, freeze_o,
                      fwd_a_sel_o, fwd_b_sel_o, id_bypass_a_o, id_bypass_b_o};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .branch_taken_i(branch_taken_i),
        .mem_busy_i(mem_busy_i), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .bubble_ex_o(bubble_ex_o), .flush_if_id_o(flush_if_id_o), .freeze_o(freeze_o),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
        .id_bypass_a_o(id_bypass_a_o), .id_bypass_b_o(id_bypass_b_o),
        .stall_cnt_o(stall_cnt_o)
    );

    function automatic row_t mk(input logic v, input logic [6:0] op, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd, input logic br,
                                input logic busy, input logic rst, input logic [10:0] ctl,
                                input logic [CNT_W-1:0] cnt);
        row_t r;
        r.v = v; r.op = op; r.r1 = r1; r.r2 = r2; r.rd = rd;
        r.br = br; r.busy = busy; r.rst = rst; r.ctl = ctl; r.cnt = cnt;
        return r;
    endfunction

    // Drives one cycle of stimulus and queues what the DUT must show for it
    task automatic drive_row(input row_t r);
        @(negedge clk_i);
        valid_i = r.v; opcode_i = r.op; rs1_i = r.r1; rs2_i = r.r2; rd_i = r.rd;
        branch_taken_i = r.br; mem_busy_i = r.busy; rst_i = r.rst;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b0; opcode_i = 7'd0; rs1_i = 5'd0; rs2_i = 5'd0;
        rd_i = 5'd0; branch_taken_i = 1'b0; mem_busy_i = 1'b0;
        @(posedge clk_i);
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, LW, 5'd1, 5'd0, 5'd5, 1, 1, 1, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_reset row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_reset row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, LW,  5'd1, 5'd0, 5'd5, 0, 0, 0, C_NONE,  0));
        rows.push_back(mk(1, ALU, 5'd5, 5'd7, 5'd6, 0, 0, 0, C_LDUSE, 0));
        rows.push_back(mk(1, ALU, 5'd5, 5'd7, 5'd6, 0, 0, 0, C_NONE,  1));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_FA10, 1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_load_use row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_load_use row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_forward();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, ALU, 5'd1, 5'd2, 5'd3, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd3, 5'd3, 5'd4, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_FAB01, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_forward row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_forward row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_fwd_priority();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, ALU, 5'd1, 5'd2, 5'd3, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd1, 5'd2, 5'd3, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd3, 5'd0, 5'd4, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_FA01, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_fwd_priority row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
        end
    endtask

    task automatic test_id_bypass();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, ADDI, 5'd1, 5'd0, 5'd8, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, BEQ, 5'd8, 5'd9, 5'd0, 0, 0, 0, C_BYPA, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_id_bypass row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
        end
    endtask

    task automatic test_x0();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, LW,  5'd2, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd0, 5'd0, 5'd1, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd0, 5'd0, 5'd2, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_x0 row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_x0 row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_branch_over_load_use();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, LW,  5'd1, 5'd0, 5'd5, 0, 0, 0, C_NONE,   0));
        rows.push_back(mk(1, ALU, 5'd5, 5'd7, 5'd6, 1, 0, 0, C_BRANCH, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE,  0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_branch_over_load_use row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_branch_over_load_use row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_branch();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, ALU, 5'd1, 5'd2, 5'd3, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, ALU, 5'd3, 5'd3, 5'd4, 1, 1, 0, C_BUSY, 0));
        rows.push_back(mk(1, ALU, 5'd3, 5'd3, 5'd4, 1, 1, 0, C_BUSY, 1));
        rows.push_back(mk(1, ALU, 5'd3, 5'd3, 5'd4, 1, 1, 0, C_BUSY, 2));
        rows.push_back(mk(1, ALU, 5'd3, 5'd3, 5'd4, 1, 0, 0, C_BRANCH, 3));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 3));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_busy_branch row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_busy_branch row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_busy();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_BUSY, 0));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_NONE, 1));
        rows.push_back(mk(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            #1;
            e = exp_q.pop_front();
            total++;
            if (ctl_obs !== e.ctl) $display("FAIL test_reset_mid_busy row%0d ctl got %b want %b", i, ctl_obs, e.ctl);
            else pass_cnt++;
            total++;
            if (stall_cnt_o !== e.cnt) $display("FAIL test_reset_mid_busy row%0d cnt got %0d want %0d", i, stall_cnt_o, e.cnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; opcode_i = 7'd0; rs1_i = 5'd0; rs2_i = 5'd0;
        rd_i = 5'd0; branch_taken_i = 1'b0; mem_busy_i = 1'b0;
        repeat (2) @(posedge clk_i);
        test_reset();
        test_load_use();
        test_forward();
        test_fwd_priority();
        test_id_bypass();
        test_x0();
        test_branch_over_load_use();
        test_busy_branch();
        test_reset_mid_busy();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Tracks the destination and source register indices of in-flight instructions in an internal shadow pipeline (EX, MEM, WB), fed from the fields produced by pipeline_decode.
- Generates stall, bubble, flush and freeze controls, EX-stage forwarding selects, and decode-stage register-file bypass selects.
- Counts stall cycles for performance monitoring.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  ID stage holds a valid instruction
opcode_i  in  7  opcode of ID-stage instruction
rs1_i  in  5  rs1 index of ID-stage instruction
rs2_i  in  5  rs2 index of ID-stage instruction
rd_i  in  5  rd index of ID-stage instruction
branch_taken_i  in  1  EX resolved a taken branch/JAL/JALR redirect
mem_busy_i  in  1  data memory not ready; pipeline must freeze
stall_if_o  out  1  hold PC
stall_id_o  out  1  hold IF/ID register
bubble_ex_o  out  1  load NOP into ID/EX
flush_if_id_o  out  1  invalidate IF/ID contents
freeze_o  out  1  hold every pipeline register (ID/EX, EX/MEM, MEM/WB included)
fwd_a_sel_o  out  2  EX operand A: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b_sel_o  out  2  EX operand B, same encoding
id_bypass_a_o  out  1  ID read of rs1 takes WB write data
id_bypass_b_o  out  1  ID read of rs2 takes WB write data
stall_cnt_o  out  CNT_W  stall-cycle count

Behaviour:
- Opcode classes:
  - writes_rd: 0000011, 0010011, 0010111, 0110011, 0110111, 1100111, 1101111.
  - uses_rs1: all except 0110111, 0010111, 1101111.
  - uses_rs2: 0110011, 0100011, 1100011.
  - is_load: 0000011.
  - valid_i=0 means no write and no uses.
- Shadow state per stage:
  - EX: valid, wr, load, rd, rs1, rs2, use1, use2.
  - MEM and WB: wr, rd.
  - A write flag is forced to 0 when rd=0.
- Shadow advance each edge, unless frozen:
  - EX <= ID decode, or all-zero if bubble_ex_o.
  - MEM <= EX.
  - WB <= MEM.
- FSM states RUN and HOLD.
  - RUN -> HOLD when mem_busy_i=1.
  - HOLD -> RUN when mem_busy_i=0.
  - In HOLD, and in any cycle mem_busy_i=1, shadow pipeline holds.
- Control priority per cycle (combinational from current inputs and shadow):
  1. mem_busy_i=1: freeze_o=stall_if_o=stall_id_o=1; bubble and flush 0. branch_taken_i is ignored; EX must hold it until busy drops.
  2. branch_taken_i=1: flush_if_id_o=1, bubble_ex_o=1, stalls 0.
  3. Load-use: EX.load AND ((use1_id AND EX.rd==rs1_i) OR (use2_id AND EX.rd==rs2_i)). Drives stall_if_o=stall_id_o=bubble_ex_o=1 for exactly one cycle; the bubble clears the condition.
  4. Otherwise all control outputs 0.
- Forwarding for the EX instruction, operand A (B identical with rs2/use2):
  - 01 if EX.use1 AND MEM.wr AND MEM.rd==EX.rs1.
  - Else 10 if EX.use1 AND WB.wr AND WB.rd==EX.rs1.
  - Else 00.
  - MEM has priority over WB.
  - Selects are valid even while frozen.
- ID bypass:
  - id_bypass_a_o = use1_id AND WB.wr AND WB.rd==rs1_i.
  - id_bypass_b_o is the same with rs2.
  - Covers the write-same-cycle regfile read.
- Stall counter:
  - Increments in any cycle with a load-use stall or mem_busy_i=1.
  - Saturates at all-ones.
  - Branch flushes are not counted.
- Reset:
  - Outputs: all outputs 0, stall_cnt_o=0.
  - Internal state: FSM=RUN, all shadow valid/wr/load/use flags 0.
  - Reset mid-stall or mid-HOLD aborts it the following cycle.
- Register x0: never produces a hazard, forward or bypass.

Test Plan:
- LW x5 then ADD x6,x5,x7 back-to-back -> one cycle with stall_if/stall_id/bubble_ex=1, next cycle fwd_a_sel_o=10, stall_cnt_o=1.
- ADD x3,x1,x2 then SUB x4,x3,x3 -> no stall, SUB in EX sees fwd_a_sel_o=fwd_b_sel_o=01.
- ADDI x8 in WB while BEQ x8,x9 in ID -> id_bypass_a_o=1, id_bypass_b_o=0.
- LW x0 then ADD x1,x0,x0 -> no stall, all selects 00, id_bypass 0.
- branch_taken_i=1 same cycle as a load-use condition -> flush_if_id_o=1, bubble_ex_o=1, stall_if_o=0, counter unchanged.
- mem_busy_i high 3 cycles with branch_taken_i=1 -> freeze_o=1 for 3 cycles, no flush, stall_cnt_o +3; flush asserted in the cycle busy drops. Reset asserted mid-busy -> all outputs 0 on next edge.
